// File: rtl/matrix_pkg.sv
// Shared constants, opcodes, FSM states and element helpers for the
// sequential matrix coprocessor.
package matrix_pkg;

  localparam int DIM    = 5;
  localparam int ELEM_W = 8;
  localparam int ACC_W  = 20;
  localparam int FLAT_W = DIM * DIM * ELEM_W;

  localparam logic [2:0] OP_ADD       = 3'b000;
  localparam logic [2:0] OP_SUB       = 3'b001;
  localparam logic [2:0] OP_MUL       = 3'b010;
  localparam logic [2:0] OP_SCALAR    = 3'b011;
  localparam logic [2:0] OP_TRANSPOSE = 3'b100;
  localparam logic [2:0] OP_NEGATE    = 3'b101;

  localparam logic [1:0] SIZE_2X2 = 2'b00;
  localparam logic [1:0] SIZE_3X3 = 2'b01;
  localparam logic [1:0] SIZE_4X4 = 2'b10;
  localparam logic [1:0] SIZE_5X5 = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  function automatic logic [4:0] flat_idx(input logic [2:0] r, input logic [2:0] c);
    return 5'(r) * 5'(DIM) + 5'(c);
  endfunction

  function automatic logic signed [ACC_W-1:0] sext(input logic [ELEM_W-1:0] e);
    return {{(ACC_W - ELEM_W){e[ELEM_W-1]}}, e};
  endfunction

endpackage

// File: rtl/matrix_seq_coprocessor_if.sv
// Command/result bundle between the HPS control unit (master) and the
// matrix coprocessor (slave).
interface matrix_seq_coprocessor_if;
  import matrix_pkg::*;

  // start is a one-cycle request honoured only when the engine is idle or
  // done; process_done is a level that stays high until the next start.
  logic              start;
  logic [2:0]        op_code;
  logic [1:0]        matrix_size;
  logic [FLAT_W-1:0] matrix_a;
  logic [FLAT_W-1:0] matrix_b;
  logic [FLAT_W-1:0] result_final;
  logic              process_done;
  logic              busy;
  logic              overflow;
  logic              op_error;

  modport master (
    output start, op_code, matrix_size, matrix_a, matrix_b,
    input  result_final, process_done, busy, overflow, op_error
  );

  modport slave (
    input  start, op_code, matrix_size, matrix_a, matrix_b,
    output result_final, process_done, busy, overflow, op_error
  );

endinterface

// File: rtl/sat_narrow.sv
// Narrows a signed accumulator-width value to a signed element, clamping
// to the element range and flagging any clamp.
module sat_narrow
  import matrix_pkg::*;
(
  input  logic signed [ACC_W-1:0]  value,
  output logic signed [ELEM_W-1:0] narrowed,
  output logic                     sat
);

  localparam int MAX_I = 2 ** (ELEM_W - 1) - 1;
  localparam int MIN_I = -(2 ** (ELEM_W - 1));
  localparam logic signed [ACC_W-1:0] MAX_V = MAX_I[ACC_W-1:0];
  localparam logic signed [ACC_W-1:0] MIN_V = MIN_I[ACC_W-1:0];

  always_comb begin
    narrowed = value[ELEM_W-1:0];
    sat      = 1'b0;
    if (value > MAX_V) begin
      narrowed = MAX_V[ELEM_W-1:0];
      sat      = 1'b1;
    end else if (value < MIN_V) begin
      narrowed = MIN_V[ELEM_W-1:0];
      sat      = 1'b1;
    end
  end

endmodule

// File: rtl/matrix_seq_coprocessor.sv
// Sequential matrix engine: one result element per cycle, or one MAC per
// cycle for matrix multiply, over latched copies of the operands.
module matrix_seq_coprocessor
  import matrix_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  matrix_seq_coprocessor_if.slave bus,
  output state_t fsm_state
);

  state_t                   state_q, state_d;
  logic [FLAT_W-1:0]        a_q, b_q, result_q;
  logic [2:0]               op_q, n_q, r_q, c_q, k_q;
  logic signed [ACC_W-1:0]  acc_q, mac_sum, elem_val;
  logic                     done_q, ovf_q, err_q;
  logic [2:0]               last_idx;
  logic                     is_mul, op_valid, col_end, row_end, k_end, last_step;
  logic [ELEM_W-1:0]        a_rc, b_rc, a_cr, b_00, a_rk, b_kc;
  logic signed [ELEM_W-1:0] narrowed;
  logic                     sat;

  function automatic logic [ELEM_W-1:0] elem(input logic [FLAT_W-1:0] m,
                                             input logic [2:0] r,
                                             input logic [2:0] c);
    return m[flat_idx(r, c) * ELEM_W +: ELEM_W];
  endfunction

  assign last_idx  = n_q - 3'd1;
  assign is_mul    = (op_q == OP_MUL);
  assign op_valid  = (op_q <= OP_NEGATE);
  assign col_end   = (c_q == last_idx);
  assign row_end   = (r_q == last_idx);
  assign k_end     = (k_q == last_idx);
  assign last_step = row_end && col_end && (!is_mul || k_end);

  always_comb begin
    a_rc = elem(a_q, r_q, c_q);
    b_rc = elem(b_q, r_q, c_q);
    a_cr = elem(a_q, c_q, r_q);
    b_00 = elem(b_q, 3'd0, 3'd0);
    a_rk = elem(a_q, r_q, k_q);
    b_kc = elem(b_q, k_q, c_q);
  end

  // Products stay in ACC_W so a full 5-term dot product never wraps.
  always_comb begin
    mac_sum  = acc_q + sext(a_rk) * sext(b_kc);
    elem_val = mac_sum;
    case (op_q)
      OP_ADD:       elem_val = sext(a_rc) + sext(b_rc);
      OP_SUB:       elem_val = sext(a_rc) - sext(b_rc);
      OP_SCALAR:    elem_val = sext(a_rc) * sext(b_00);
      OP_TRANSPOSE: elem_val = sext(a_cr);
      OP_NEGATE:    elem_val = {ACC_W{1'b0}} - sext(a_rc);
      default:      elem_val = mac_sum;
    endcase
  end

  sat_narrow u_sat (
    .value    (elem_val),
    .narrowed (narrowed),
    .sat      (sat)
  );

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (bus.start) state_d = COMPUTE;
      COMPUTE:    if (!op_valid || last_step) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      n_q      <= 3'd2;
      r_q      <= '0;
      c_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (bus.start) begin
            a_q      <= bus.matrix_a;
            b_q      <= bus.matrix_b;
            op_q     <= bus.op_code;
            n_q      <= {1'b0, bus.matrix_size} + 3'd2;
            r_q      <= '0;
            c_q      <= '0;
            k_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
          end
        end
        COMPUTE: begin
          if (!op_valid) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
          end else if (is_mul && !k_end) begin
            acc_q <= mac_sum;
            k_q   <= k_q + 3'd1;
          end else begin
            result_q[flat_idx(r_q, c_q) * ELEM_W +: ELEM_W] <= narrowed;
            if (sat) ovf_q <= 1'b1;
            acc_q <= '0;
            k_q   <= '0;
            // Counters freeze on the final element so indices stay in range.
            if (last_step) begin
              done_q <= 1'b1;
            end else if (col_end) begin
              c_q <= '0;
              r_q <= r_q + 3'd1;
            end else begin
              c_q <= c_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.result_final = result_q;
  assign bus.process_done = done_q;
  assign bus.busy         = (state_q == COMPUTE);
  assign bus.overflow     = ovf_q;
  assign bus.op_error     = err_q;
  assign fsm_state        = state_q;

endmodule

// File: tb/tb_matrix_seq_coprocessor.sv
// Bench for matrix_seq_coprocessor: directed and random operations checked
// against an arithmetic reference model of the matrix operations.
module tb_matrix_seq_coprocessor;
  import matrix_pkg::*;

  logic   clk;
  logic   reset;
  state_t fsm_state;
  int     checks;
  int     errors;
  int     ma[DIM][DIM];
  int     mb[DIM][DIM];

  matrix_seq_coprocessor_if bus ();

  matrix_seq_coprocessor dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .fsm_state (fsm_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [FLAT_W-1:0] obs,
                       input logic [FLAT_W-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic int rnd_elem();
    return int'($urandom_range(0, 255)) - 128;
  endfunction

  task automatic fill_random();
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        ma[r][c] = rnd_elem();
        mb[r][c] = rnd_elem();
      end
  endtask

  task automatic set_const(input int av, input int bv, input int n);
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        ma[r][c] = av;
        mb[r][c] = bv;
      end
  endtask

  task automatic drive_operands();
    logic [FLAT_W-1:0] va, vb;
    int tmp;
    va = '0;
    vb = '0;
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++) begin
        tmp = ma[r][c];
        va[(r * DIM + c) * 8 +: 8] = tmp[7:0];
        tmp = mb[r][c];
        vb[(r * DIM + c) * 8 +: 8] = tmp[7:0];
      end
    bus.matrix_a = va;
    bus.matrix_b = vb;
  endtask

  // Reference: plain matrix arithmetic on integers, then clamp to 8 bits.
  task automatic model(input int op, input int n, output logic [FLAT_W-1:0] res,
                       output logic ovf, output logic err, output int lat);
    int v;
    res = '0;
    ovf = 1'b0;
    err = (op > 5);
    lat = err ? 1 : ((op == 2) ? n * n * n : n * n);
    if (!err) begin
      for (int r = 0; r < n; r++)
        for (int c = 0; c < n; c++) begin
          case (op)
            0: v = ma[r][c] + mb[r][c];
            1: v = ma[r][c] - mb[r][c];
            2: begin
              v = 0;
              for (int k = 0; k < n; k++) v += ma[r][k] * mb[k][c];
            end
            3: v = ma[r][c] * mb[0][0];
            4: v = ma[c][r];
            default: v = -ma[r][c];
          endcase
          if (v > 127) begin
            v = 127;
            ovf = 1'b1;
          end else if (v < -128) begin
            v = -128;
            ovf = 1'b1;
          end
          res[(r * DIM + c) * 8 +: 8] = v[7:0];
        end
    end
  endtask

  task automatic run_op(input string name, input int op, input int size, input bit pulse_mid);
    logic [FLAT_W-1:0] exp_res, rnd_vec;
    logic exp_ovf, exp_err;
    int lat, cycles;
    model(op, size + 2, exp_res, exp_ovf, exp_err, lat);
    @(negedge clk);
    drive_operands();
    bus.op_code     = 3'(op);
    bus.matrix_size = 2'(size);
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, ".busy_at_start"}, bus.busy, 1);
    check({name, ".done_cleared"}, bus.process_done, 0);
    check({name, ".result_cleared"}, bus.result_final, '0);
    // Scramble live inputs; only the latched copies may matter now.
    for (int i = 0; i < FLAT_W; i += 32) rnd_vec[i +: 32] = $urandom;
    bus.matrix_a    = rnd_vec;
    bus.matrix_b    = ~rnd_vec;
    bus.op_code     = 3'($urandom_range(0, 7));
    bus.matrix_size = 2'($urandom_range(0, 3));
    cycles = 0;
    while (bus.process_done !== 1'b1 && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
      bus.start = pulse_mid && (cycles == 2);
    end
    bus.start = 1'b0;
    check({name, ".latency"}, cycles, lat);
    check({name, ".result"}, bus.result_final, exp_res);
    check({name, ".overflow"}, bus.overflow, exp_ovf);
    check({name, ".op_error"}, bus.op_error, exp_err);
    check({name, ".busy_end"}, bus.busy, 0);
    check({name, ".state_done"}, fsm_state, DONE);
    repeat (2) @(posedge clk);
    #1;
    check({name, ".result_held"}, bus.result_final, exp_res);
    check({name, ".done_held"}, bus.process_done, 1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    bus.start       = 1'b0;
    bus.op_code     = OP_ADD;
    bus.matrix_size = SIZE_2X2;
    bus.matrix_a    = '0;
    bus.matrix_b    = '0;
    fill_random();

    // Reset held with start asserted: reset must win.
    reset     = 1'b1;
    bus.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset.state", fsm_state, IDLE);
    check("reset.busy", bus.busy, 0);
    check("reset.done", bus.process_done, 0);
    check("reset.result", bus.result_final, '0);
    check("reset.overflow", bus.overflow, 0);
    check("reset.op_error", bus.op_error, 0);
    bus.start = 1'b0;
    reset     = 1'b0;

    fill_random();
    ma[0][0] = 1;  ma[0][1] = 2;  ma[1][0] = 3;  ma[1][1] = 4;
    mb[0][0] = 10; mb[0][1] = 20; mb[1][0] = 30; mb[1][1] = 40;
    run_op("add2", 0, 0, 1'b0);
    check("add2.e00", bus.result_final[7:0], 11);
    check("add2.e01", bus.result_final[15:8], 22);
    check("add2.e10", bus.result_final[47:40], 33);
    check("add2.e11", bus.result_final[55:48], 44);

    fill_random();
    ma[0][0] = 1; ma[0][1] = 2; ma[1][0] = 3; ma[1][1] = 4;
    mb[0][0] = 5; mb[0][1] = 6; mb[1][0] = 7; mb[1][1] = 8;
    run_op("mul2", 2, 0, 1'b0);
    check("mul2.e00", bus.result_final[7:0], 19);
    check("mul2.e01", bus.result_final[15:8], 22);
    check("mul2.e10", bus.result_final[47:40], 43);
    check("mul2.e11", bus.result_final[55:48], 50);

    fill_random();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++) begin
        ma[r][c] = (r == c) ? 1 : 0;
        mb[r][c] = r * 3 + c + 1;
      end
    run_op("mul3_ident", 2, 1, 1'b0);

    set_const(127, 127, 5);
    run_op("mul5_sat", 2, 3, 1'b0);

    fill_random();
    set_const(100, 100, 2);
    run_op("add_sat", 0, 0, 1'b0);
    set_const(-100, 100, 2);
    run_op("sub_sat", 1, 0, 1'b0);
    set_const(-128, 0, 2);
    run_op("neg_min", 5, 0, 1'b0);
    set_const(3, -2, 2);
    run_op("scalar", 3, 0, 1'b0);
    check("scalar.e00", bus.result_final[7:0], 8'hFA);

    fill_random();
    run_op("op_111", 7, 2, 1'b0);
    run_op("op_110", 6, 3, 1'b0);
    fill_random();
    run_op("start_mid", 0, 1, 1'b1);
    run_op("transpose4", 4, 2, 1'b0);

    // Reset sampled at edge 10 of a 4x4 multiply.
    fill_random();
    @(negedge clk);
    drive_operands();
    bus.op_code     = OP_MUL;
    bus.matrix_size = SIZE_4X4;
    bus.start       = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("abort.busy", bus.busy, 0);
    check("abort.done", bus.process_done, 0);
    check("abort.result", bus.result_final, '0);
    check("abort.state", fsm_state, IDLE);
    reset = 1'b0;
    fill_random();
    run_op("after_abort_add", 0, 3, 1'b0);

    for (int t = 0; t < 20; t++) begin
      fill_random();
      run_op($sformatf("rand%0d", t), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
